// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 incrementing-burst master: one request = 1..16 beats.
// Linear bursts (bte=00), cti 010/111, slave retry and error handling.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, sync active-high reset
//   req_i/req_adr_i/req_we_i/req_len_i/req_ready_o   request handshake
//   wr_dat_i/wr_sel_i/wr_ready_o write beat source (consumed on ack)
//   rd_dat_o/rd_valid_o         read beat sink
//   done_o/err_o                completion pulses
//   wb_*                        Wishbone B3 master port
module wb_b3_burst_master #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int max_rty = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          req_i,
  input  logic [aw-1:0] req_adr_i,
  input  logic          req_we_i,
  input  logic [3:0]    req_len_i,
  output logic          req_ready_o,
  input  logic [dw-1:0] wr_dat_i,
  input  logic [3:0]    wr_sel_i,
  output logic          wr_ready_o,
  output logic [dw-1:0] rd_dat_o,
  output logic          rd_valid_o,
  output logic          done_o,
  output logic          err_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  output logic [dw-1:0] wb_dat_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  input  logic [dw-1:0] wb_dat_i
);

  localparam int RW = $clog2(max_rty + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_RETRY = 2'd2;

  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  logic [1:0]    r_state;
  logic [aw-1:0] r_adr;
  logic          r_we;
  logic [4:0]    r_cnt;
  logic [2:0]    r_cti;
  logic [RW-1:0] r_rty;
  logic [dw-1:0] r_rd_dat;
  logic          r_rd_valid;
  logic          r_done;
  logic          r_err;

  wire w_run   = ~wb_rst_i;
  wire w_idle  = (r_state == S_IDLE);
  wire w_burst = (r_state == S_BURST);
  wire w_last  = (r_cnt == 5'd1);
  wire w_rmax  = (r_rty == RW'(max_rty));
  // Retry budget exhausted: the next retry is escalated to an error.
  wire w_fail  = wb_err_i | (wb_rty_i & ~wb_ack_i & w_rmax);
  wire w_unused = &{1'b0, req_adr_i[1:0]};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_adr      <= '0;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      r_cti      <= '0;
      r_rty      <= '0;
      r_rd_dat   <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_adr   <= {req_adr_i[aw-1:2], 2'b00};
            r_we    <= req_we_i;
            r_cnt   <= {1'b0, req_len_i} + 5'd1;
            r_cti   <= (req_len_i == 4'd0) ? CTI_END : CTI_INC;
            r_rty   <= '0;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_fail) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (wb_ack_i) begin
            r_rty <= '0;
            if (!r_we) begin
              r_rd_dat   <= wb_dat_i;
              r_rd_valid <= 1'b1;
            end
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_adr <= r_adr + aw'(4);
              r_cnt <= r_cnt - 5'd1;
              r_cti <= (r_cnt == 5'd2) ? CTI_END : CTI_INC;
            end
          end else if (wb_rty_i) begin
            r_rty   <= r_rty + RW'(1);
            r_state <= S_RETRY;
          end
        end
        S_RETRY: r_state <= S_BURST;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Every output is forced low while reset is held.
  assign req_ready_o = w_run & w_idle & ~w_unused;
  assign wr_ready_o  = w_run & wb_ack_i & r_we & w_burst;
  assign rd_dat_o    = w_run ? r_rd_dat : '0;
  assign rd_valid_o  = w_run & r_rd_valid;
  assign done_o      = w_run & r_done;
  assign err_o       = w_run & r_err;
  assign wb_adr_o    = w_run ? r_adr : '0;
  assign wb_bte_o    = 2'b00;
  assign wb_cti_o    = w_run ? r_cti : '0;
  assign wb_cyc_o    = w_run & w_burst;
  assign wb_stb_o    = w_run & w_burst;
  assign wb_we_o     = w_run & r_we;
  assign wb_sel_o    = ~w_run ? 4'h0 : (r_we ? wr_sel_i : 4'hF);
  assign wb_dat_o    = w_run ? wr_dat_i : '0;

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Bench for wb_b3_burst_master: scripted slave responses, memory
// model, directed and random bursts checked against a beat-level model.
module tb_wb_b3_burst_master;

  localparam int P_ACK  = 0;
  localparam int P_ERR  = 1;
  localparam int P_RTY  = 2;
  localparam int P_WAIT = 3;
  localparam int MAXR   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [31:0] req_adr_i;
  logic        req_we_i;
  logic [3:0]  req_len_i;
  logic        req_ready_o;
  logic [31:0] wr_dat_i;
  logic [3:0]  wr_sel_i;
  logic        wr_ready_o;
  logic [31:0] rd_dat_o;
  logic        rd_valid_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] wb_adr_o;
  logic [1:0]  wb_bte_o;
  logic [2:0]  wb_cti_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic [31:0] wb_dat_i;

  always #5 clk = ~clk;

  wb_b3_burst_master #(.dw(32), .aw(32), .max_rty(MAXR)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_i(req_i), .req_adr_i(req_adr_i),
    .req_we_i(req_we_i), .req_len_i(req_len_i),
    .req_ready_o(req_ready_o),
    .wr_dat_i(wr_dat_i), .wr_sel_i(wr_sel_i),
    .wr_ready_o(wr_ready_o),
    .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o),
    .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_bte_o(wb_bte_o),
    .wb_cti_o(wb_cti_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i)
  );

  int          plan [64];
  logic [7:0]  stb_cnt  = 8'd0;
  logic [7:0]  stb_base = 8'd0;
  logic [3:0]  wcnt     = 4'd0;
  logic [3:0]  wbase    = 4'd0;
  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];
  logic [31:0] wq  [16];
  logic [3:0]  wsq [16];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx;
  logic [31:0] ld_val;
  int          total = 0;
  int          bad   = 0;

  logic [7:0] sidx;
  logic [3:0] widx;
  int         presp;

  // Slave: zero-wait responder driven by the per-strobe plan.
  always_comb begin
    sidx     = stb_cnt - stb_base;
    widx     = wcnt - wbase;
    presp    = (sidx < 8'd64) ? plan[sidx[5:0]] : P_ACK;
    wb_ack_i = wb_cyc_o & wb_stb_o & (presp == P_ACK);
    wb_err_i = wb_cyc_o & wb_stb_o & (presp == P_ERR);
    wb_rty_i = wb_cyc_o & wb_stb_o & (presp == P_RTY);
    wb_dat_i = mem[wb_adr_o[9:2]];
    wr_dat_i = wq[widx];
    wr_sel_i = wsq[widx];
  end

  always @(posedge clk) begin
    if (ld_en)
      mem[ld_idx] <= ld_val;
    else if (wb_cyc_o & wb_stb_o & wb_ack_i & wb_we_o & ~wb_err_i)
      for (int b = 0; b < 4; b++)
        if (wb_sel_o[b])
          mem[wb_adr_o[9:2]][b*8 +: 8] <= wb_dat_o[b*8 +: 8];
    if (wb_cyc_o & wb_stb_o) stb_cnt <= stb_cnt + 8'd1;
    if (wr_ready_o) wcnt <= wcnt + 4'd1;
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic plan_acks();
    for (int i = 0; i < 64; i++) plan[i] = P_ACK;
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] adr,
                          input bit we, input int len,
                          input int hold);
    logic [31:0] ea[$];
    logic [2:0]  ec[$];
    logic [31:0] er[$];
    logic [31:0] oa[$];
    logic [2:0]  oc[$];
    logic [31:0] orr[$];
    logic [31:0] a;
    int n, r, i, p, beat, e_done, e_err, e_gaps;
    int nd, ne, gaps, nwr, last_stb, end_t, post, nbad;
    bit seen;
    logic [3:0] xsel;
    // Reference: walk the response script beat by beat.
    a = adr & ~32'd3; n = len + 1; r = 0; i = 0; beat = 0;
    e_done = 0; e_err = 0; e_gaps = 0;
    while (1) begin
      p = (i < 64) ? plan[i] : P_ACK;
      i++;
      if (p == P_ERR) begin e_err = 1; break; end
      if (p == P_RTY) begin
        if (r == MAXR) begin e_err = 1; break; end
        r++; e_gaps++;
      end
      if (p == P_ACK) begin
        ea.push_back(a);
        ec.push_back(n > 1 ? 3'b010 : 3'b111);
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (wsq[beat][b])
              exp_mem[a[9:2]][b*8 +: 8] = wq[beat][b*8 +: 8];
        end else
          er.push_back(exp_mem[a[9:2]]);
        beat++; a = a + 32'd4; n--; r = 0;
        if (n == 0) begin e_done = 1; break; end
      end
    end
    @(negedge clk);
    stb_base = stb_cnt; wbase = wcnt;
    req_i = 1'b1; req_adr_i = adr;
    req_we_i = we; req_len_i = len[3:0];
    #1 chk({tag, " ready"}, 128'(req_ready_o), 128'(1));
    @(posedge clk);
    nd = 0; ne = 0; gaps = 0; nwr = 0; nbad = 0;
    last_stb = 0; end_t = -1; post = 0; seen = 0;
    for (int t = 1; t < 300; t++) begin
      @(negedge clk);
      if (t == 1 && hold > 1) begin
        req_adr_i = adr ^ 32'h0000_5550;
        req_len_i = 4'd0;
      end
      if (t == hold) req_i = 1'b0;
      if (seen && !wb_cyc_o && nd == 0 && ne == 0 &&
          !done_o && !err_o) gaps++;
      if (wb_cyc_o & wb_stb_o) begin
        seen = 1; last_stb = t;
        xsel = we ? wsq[oa.size() % 16] : 4'hF;
        if (wb_sel_o !== xsel || wb_bte_o !== 2'b00 ||
            wb_we_o !== we) nbad++;
        if (we && wb_dat_o !== wq[oa.size() % 16]) nbad++;
        if (wb_ack_i & ~wb_err_i) begin
          oa.push_back(wb_adr_o);
          oc.push_back(wb_cti_o);
        end
      end
      if (rd_valid_o) orr.push_back(rd_dat_o);
      if (wr_ready_o) nwr++;
      if (done_o) begin nd++; end_t = t; end
      if (err_o) begin ne++; end_t = t; end
      if (nd + ne > 0) post++;
      if (post >= 3) break;
    end
    req_i = 1'b0;
    chk({tag, " beats"}, 128'(oa.size()), 128'(ea.size()));
    for (int k = 0; k < ea.size() && k < oa.size(); k++) begin
      chk($sformatf("%s adr%0d", tag, k), 128'(oa[k]), 128'(ea[k]));
      chk($sformatf("%s cti%0d", tag, k), 128'(oc[k]), 128'(ec[k]));
    end
    chk({tag, " nrd"}, 128'(orr.size()), 128'(er.size()));
    for (int k = 0; k < er.size() && k < orr.size(); k++)
      chk($sformatf("%s rd%0d", tag, k), 128'(orr[k]), 128'(er[k]));
    chk({tag, " nwr"}, 128'(nwr), 128'(we ? ea.size() : 0));
    chk({tag, " done"}, 128'(nd), 128'(e_done));
    chk({tag, " err"}, 128'(ne), 128'(e_err));
    chk({tag, " gaps"}, 128'(gaps), 128'(e_gaps));
    chk({tag, " endt"}, 128'(end_t), 128'(last_stb + 1));
    chk({tag, " bus"}, 128'(nbad), 128'(0));
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({req_ready_o, wr_ready_o, rd_dat_o, rd_valid_o,
                 done_o, err_o, wb_adr_o, wb_bte_o, wb_cti_o,
                 wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o});
  endfunction

  initial begin
    int nack;
    int len;
    bit we;
    logic [31:0] adr;
    rst = 1'b1; req_i = 1'b0; req_adr_i = '0;
    req_we_i = 1'b0; req_len_i = '0;
    plan_acks();
    for (int i = 0; i < 16; i++) begin
      wq[i] = $urandom; wsq[i] = 4'hF;
    end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_idx = 8'(i);
      ld_val = (i >= 'h40 && i <= 'h43) ?
               32'hA0A0_0000 + 32'(i) : $urandom;
      exp_mem[i] = ld_val;
    end
    @(negedge clk);
    ld_en = 1'b0;
    chk("reset outs", all_outs(), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel ready", 128'(req_ready_o), 128'(1));

    run_xfer("rd4", 32'h100, 1'b0, 3, 1);

    wq[0] = 32'h1234_5678; wsq[0] = 4'h3;
    run_xfer("wr1", 32'h20, 1'b1, 0, 1);
    run_xfer("rdbk", 32'h20, 1'b0, 0, 1);

    plan[1] = P_ERR;
    run_xfer("err2", 32'h100, 1'b0, 3, 1);

    plan_acks(); plan[1] = P_RTY;
    run_xfer("rty", 32'h180, 1'b0, 2, 1);

    plan_acks();
    for (int i = 1; i <= 8; i++) plan[i] = P_RTY;
    run_xfer("rty8", 32'h184, 1'b0, 2, 1);

    plan_acks();
    for (int i = 1; i <= 9; i++) plan[i] = P_RTY;
    run_xfer("rty9", 32'h188, 1'b0, 2, 1);

    plan_acks();
    run_xfer("wrap", 32'hFFFF_FFF9, 1'b0, 3, 1);
    run_xfer("busy", 32'h200, 1'b0, 15, 10);

    // Reset in the middle of a 16-beat burst.
    @(negedge clk);
    stb_base = stb_cnt; wbase = wcnt;
    req_i = 1'b1; req_adr_i = 32'h300;
    req_we_i = 1'b0; req_len_i = 4'd15;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0; nack = 0;
    for (int t = 0; t < 40; t++) begin
      if (wb_cyc_o & wb_ack_i) nack++;
      if (nack == 5) break;
      @(negedge clk);
    end
    chk("rst acks", 128'(nack), 128'(5));
    rst = 1'b1;
    @(negedge clk);
    chk("rst mid outs", all_outs(), 128'(0));
    @(negedge clk);
    chk("rst hold outs", all_outs(), 128'(0));
    rst = 1'b0;
    #1 chk("rst rel ready", 128'(req_ready_o), 128'(1));

    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 64; i++) begin
        len = int'($urandom_range(0, 99));
        plan[i] = len < 72 ? P_ACK : len < 82 ? P_WAIT :
                  len < 96 ? P_RTY : P_ERR;
      end
      for (int i = 0; i < 16; i++) begin
        wq[i] = $urandom; wsq[i] = 4'($urandom);
      end
      we  = 1'($urandom);
      adr = $urandom;
      len = int'($urandom_range(0, 15));
      run_xfer($sformatf("rnd%0d", n), adr, we, len, 1);
    end

    plan_acks();
    run_xfer("final", 32'h40, 1'b0, 15, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_b3_burst_master.md
WB_B3_BURST_MASTER -- requirements
Module: wb_b3_burst_master

Interface
REQ-001 SHALL have parameter: dw, 32, data width (only 32 supported).
REQ-002 SHALL have parameter: aw, 32, address width.
REQ-003 SHALL have parameter: max_rty, 8, consecutive retries tolerated before error.
REQ-004 SHALL use a single clock and a synchronous active-high reset; no other clock domains.
REQ-005 SHALL have the following ports (clock and reset first):
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- req_i  in  1  transfer request
- req_adr_i  in  aw  byte start address; bits [1:0] ignored
- req_we_i  in  1  1 = write, 0 = read
- req_len_i  in  4  beats minus one (0..15 gives 1..16 beats)
- req_ready_o  out  1  request accepted when high with req_i
- wr_dat_i  in  dw  current write beat data
- wr_sel_i  in  4  current write beat byte enables
- wr_ready_o  out  1  current write beat consumed
- rd_dat_o  out  dw  read beat data
- rd_valid_o  out  1  rd_dat_o valid
- done_o  out  1  one-cycle pulse on successful completion
- err_o  out  1  one-cycle pulse on failed completion
- wb_adr_o  out  aw  Wishbone address
- wb_bte_o  out  2  burst type extension
- wb_cti_o  out  3  cycle type identifier
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_sel_o  out  4  byte select
- wb_dat_o  out  dw  write data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error
- wb_rty_i  in  1  retry
- wb_dat_i  in  dw  read data

Function
REQ-006 SHALL implement states IDLE, BURST and RETRY.
REQ-007 SHALL drive req_ready_o high only in IDLE; acceptance (req_i & req_ready_o) latches {adr[aw-1:2],2'b00}, we and beats = req_len_i+1, and moves to BURST on the next edge.
REQ-008 SHALL ignore req_i outside IDLE.
REQ-009 In BURST, SHALL drive wb_cyc_o = wb_stb_o = 1 and wb_bte_o = 2'b00 (linear), with wb_adr_o and wb_cti_o registered.
REQ-010 SHALL drive wb_cti_o = 3'b010 while remaining beats > 1 and 3'b111 on the last beat; a 1-beat request issues 3'b111 only.
REQ-011 On wb_ack_i in BURST, SHALL on the next edge advance wb_adr_o by 4 (modulo 2^aw, wrap permitted), decrement the remaining count, and update wb_cti_o; this gives zero-wait back-to-back beats.
REQ-012 SHALL drive wb_we_o from the latched we; wb_sel_o = wr_sel_i for writes and 4'hF for reads; wb_dat_o = wr_dat_i combinationally.
REQ-013 SHALL assert wr_ready_o = wb_ack_i & wb_we_o & (state == BURST), combinationally.
REQ-014 SHALL, on a read ack in BURST, register rd_dat_o <= wb_dat_i and pulse rd_valid_o high for one cycle on the next edge.
REQ-015 On the ack of the last beat, SHALL on the next edge drop cyc/stb, return to IDLE and pulse done_o for one cycle.
REQ-016 On wb_err_i in BURST, SHALL on the next edge drop cyc/stb, pulse err_o, discard the remaining beats and return to IDLE; done_o SHALL NOT pulse.
REQ-017 On wb_rty_i in BURST, SHALL drop cyc/stb for exactly one cycle (RETRY), then re-enter BURST at the current address and remaining count.
REQ-018 A retry counter SHALL clear on any ack; on reaching max_rty consecutive retries, the block SHALL treat the next retry as an error (REQ-016).
REQ-019 Simultaneous responses SHALL take priority err > ack > rty.
REQ-020 SHALL ignore wb_ack_i, wb_err_i and wb_rty_i outside BURST.

Reset
REQ-021 While wb_rst_i is high, all outputs SHALL be 0 (including req_ready_o), the state SHALL be IDLE and all counters SHALL be cleared; req_ready_o SHALL be 1 in the first cycle after release.
REQ-022 Reset mid-burst SHALL drop cyc/stb at that edge without pulsing done_o or err_o.

Verification
REQ-023 Read test: with the slave preloaded with mem[0x40..0x43] = A,B,C,D, a read of req_adr_i = 0x100, len = 3 SHALL produce wb_adr_o 0x100/0x104/0x108/0x10C, wb_cti_o 010/010/010/111, rd_dat_o A,B,C,D and done_o one cycle after the last ack.
REQ-024 Single write test: a write of adr = 0x20, len = 0, sel = 4'h3, data 0x12345678 SHALL issue one beat with wb_cti_o = 111 and one wr_ready_o pulse; readback SHALL return the lower 16 bits updated.
REQ-025 Error test: a slave err on beat 2 of a 4-beat read SHALL cause cyc to drop next cycle, one err_o pulse, only 1 rd_valid_o and no done_o.
REQ-026 Retry test: rty on beat 2 of 3 SHALL cause cyc low for 1 cycle, then resume at adr+4 with cti 010 then 111; 9 consecutive rty SHALL cause an err_o pulse.
REQ-027 Busy/reset test: req_i asserted during a 16-beat burst SHALL be ignored; wb_rst_i at beat 5 SHALL produce all outputs 0 next cycle and req_ready_o = 1 after release.
